// File: rtl/pulse_sched_pkg.sv
// Shared widths, scheduler state encoding and the packed command record used by the
// pulse scheduler block.
package pulse_sched_pkg;

    localparam int unsigned PHASE_WIDTH_DEF    = 17;
    localparam int unsigned FREQ_WIDTH_DEF     = 9;
    localparam int unsigned AMP_WIDTH_DEF      = 16;
    localparam int unsigned CFG_WIDTH_DEF      = 4;
    localparam int unsigned ENV_WORD_WIDTH_DEF = 24;
    localparam int unsigned TIME_WIDTH_DEF     = 32;
    localparam int unsigned DEPTH_DEF          = 8;

    typedef enum logic [1:0] {
        StEmpty,
        StArmed,
        StIssue
    } sched_state_e;

    typedef struct packed {
        logic [TIME_WIDTH_DEF-1:0]     time_stamp;
        logic [ENV_WORD_WIDTH_DEF-1:0] env_word;
        logic [CFG_WIDTH_DEF-1:0]      cfg;
        logic [AMP_WIDTH_DEF-1:0]      amp;
        logic [FREQ_WIDTH_DEF-1:0]     freq;
        logic [PHASE_WIDTH_DEF-1:0]    phase;
    } pulse_cmd_t;

    // Width of one buffered command word; layout matches pulse_cmd_t, time in the MSBs.
    function automatic int unsigned cmd_bits(input int unsigned phase_w, input int unsigned freq_w,
                                             input int unsigned amp_w, input int unsigned cfg_w,
                                             input int unsigned env_w, input int unsigned time_w);
        return phase_w + freq_w + amp_w + cfg_w + env_w + time_w;
    endfunction

endpackage

// File: rtl/pulse_scheduler_if.sv
// Command channel into the pulse scheduler: valid/ready handshake plus pulse fields and
// the timestamp at which the pulse should be issued.
interface pulse_scheduler_if
    import pulse_sched_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH    = PHASE_WIDTH_DEF,
    parameter int unsigned FREQ_WIDTH     = FREQ_WIDTH_DEF,
    parameter int unsigned AMP_WIDTH      = AMP_WIDTH_DEF,
    parameter int unsigned CFG_WIDTH      = CFG_WIDTH_DEF,
    parameter int unsigned ENV_WORD_WIDTH = ENV_WORD_WIDTH_DEF,
    parameter int unsigned TIME_WIDTH     = TIME_WIDTH_DEF
);

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [PHASE_WIDTH-1:0]    cmd_phase;
    logic [FREQ_WIDTH-1:0]     cmd_freq;
    logic [AMP_WIDTH-1:0]      cmd_amp;
    logic [ENV_WORD_WIDTH-1:0] cmd_env_word;
    logic [CFG_WIDTH-1:0]      cmd_cfg;
    logic [TIME_WIDTH-1:0]     cmd_time;

    modport master (
        output cmd_valid, cmd_phase, cmd_freq, cmd_amp, cmd_env_word, cmd_cfg, cmd_time,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_phase, cmd_freq, cmd_amp, cmd_env_word, cmd_cfg, cmd_time,
        output cmd_ready
    );

endinterface

// File: rtl/pulse_cmd_fifo.sv
// Synchronous command buffer with registered occupancy. The head word falls through
// combinationally; the entry behind it is exposed so the scheduler can look one ahead.
module pulse_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [WIDTH-1:0]           second,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);

    assign head   = mem[rd_ptr];
    assign second = mem[rd_ptr + AW'(1)];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pulse_scheduler.sv
// Timestamped pulse scheduler: buffers commands and commits each one to the pulse outputs
// when the free-running timer reaches its timestamp. PULSE_SCHED_LATE_DROP_EN drops late heads.
module pulse_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH    = PHASE_WIDTH_DEF,
    parameter int unsigned FREQ_WIDTH     = FREQ_WIDTH_DEF,
    parameter int unsigned AMP_WIDTH      = AMP_WIDTH_DEF,
    parameter int unsigned CFG_WIDTH      = CFG_WIDTH_DEF,
    parameter int unsigned ENV_WORD_WIDTH = ENV_WORD_WIDTH_DEF,
    parameter int unsigned TIME_WIDTH     = TIME_WIDTH_DEF,
    parameter int unsigned DEPTH          = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      time_rst,
    pulse_scheduler_if.slave          cmd,
    output logic [PHASE_WIDTH-1:0]    phase,
    output logic [FREQ_WIDTH-1:0]     freq,
    output logic [AMP_WIDTH-1:0]      amp,
    output logic [ENV_WORD_WIDTH-1:0] env_word,
    output logic [CFG_WIDTH-1:0]      cfg,
    output logic                      cstrobe,
    output logic [TIME_WIDTH-1:0]     cur_time,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      late_err,
    input  logic                      err_clr,
    output logic                      busy
);

    localparam int unsigned W  = cmd_bits(PHASE_WIDTH, FREQ_WIDTH, AMP_WIDTH, CFG_WIDTH,
                                          ENV_WORD_WIDTH, TIME_WIDTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    localparam int unsigned OFF_FREQ = PHASE_WIDTH;
    localparam int unsigned OFF_AMP  = OFF_FREQ + FREQ_WIDTH;
    localparam int unsigned OFF_CFG  = OFF_AMP + AMP_WIDTH;
    localparam int unsigned OFF_ENV  = OFF_CFG + CFG_WIDTH;
    localparam int unsigned OFF_TIME = OFF_ENV + ENV_WORD_WIDTH;

    sched_state_e          state_q;
    sched_state_e          state_d;
    logic [W-1:0]          push_word;
    logic [W-1:0]          head_word;
    logic [W-1:0]          second_word;
    logic [W-1:0]          nh_word;
    logic                  nh_valid;
    logic [TIME_WIDTH-1:0] time_next;
    logic [TIME_WIDTH-1:0] d_next;
    logic                  push;
    logic                  issue;
    logic                  late;
    logic                  fire;

    assign cmd.cmd_ready = (fifo_count < CW'(DEPTH));
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign push_word     = {cmd.cmd_time, cmd.cmd_env_word, cmd.cmd_cfg, cmd.cmd_amp,
                            cmd.cmd_freq, cmd.cmd_phase};
    assign busy          = (fifo_count != '0);

    pulse_cmd_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_word),
        .pop       (issue),
        .head      (head_word),
        .second    (second_word),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset || time_rst) begin
            cur_time <= '0;
        end else begin
            cur_time <= cur_time + TIME_WIDTH'(1);
        end
    end

    assign time_next = time_rst ? '0 : cur_time + TIME_WIDTH'(1);

    // ISSUE is only entered with d <= 0, so any mismatch at pop time means the head is late.
    assign issue = (state_q == StIssue);
    assign late  = issue && (head_word[OFF_TIME +: TIME_WIDTH] != cur_time);

`ifdef PULSE_SCHED_LATE_DROP_EN
    assign fire = issue && !late;
`else
    assign fire = issue;
`endif

    // Classify the entry that will sit at the head next cycle against next cycle's timer.
    always_comb begin
        nh_valid = 1'b0;
        nh_word  = head_word;
        if (issue) begin
            if (fifo_count >= CW'(2)) begin
                nh_valid = 1'b1;
                nh_word  = second_word;
            end else if (push) begin
                nh_valid = 1'b1;
                nh_word  = push_word;
            end
        end else if (fifo_count != '0) begin
            nh_valid = 1'b1;
            nh_word  = head_word;
        end else if (push) begin
            nh_valid = 1'b1;
            nh_word  = push_word;
        end

        d_next = nh_word[OFF_TIME +: TIME_WIDTH] - time_next;
        if (!nh_valid) begin
            state_d = StEmpty;
        end else if (!d_next[TIME_WIDTH-1] && (d_next != '0)) begin
            state_d = StArmed;
        end else begin
            state_d = StIssue;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StEmpty;
            cstrobe  <= 1'b0;
            phase    <= '0;
            freq     <= '0;
            amp      <= '0;
            env_word <= '0;
            cfg      <= '0;
            late_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cstrobe <= fire;
            if (fire) begin
                phase    <= head_word[0 +: PHASE_WIDTH];
                freq     <= head_word[OFF_FREQ +: FREQ_WIDTH];
                amp      <= head_word[OFF_AMP +: AMP_WIDTH];
                cfg      <= head_word[OFF_CFG +: CFG_WIDTH];
                env_word <= head_word[OFF_ENV +: ENV_WORD_WIDTH];
            end
            if (late) begin
                late_err <= 1'b1;
            end else if (err_clr) begin
                late_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Scoreboard bench for pulse_scheduler; a second 8-bit-timer instance covers timer wrap.
module tb_pulse_scheduler;
    import pulse_sched_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, time_rst, err_clr;
    logic w_time_rst, w_err_clr;

    logic [PHASE_WIDTH_DEF-1:0]    phase;
    logic [FREQ_WIDTH_DEF-1:0]     freq;
    logic [AMP_WIDTH_DEF-1:0]      amp;
    logic [ENV_WORD_WIDTH_DEF-1:0] env_word;
    logic [CFG_WIDTH_DEF-1:0]      cfg;
    logic                          cstrobe, late_err, busy;
    logic [31:0]                   cur_time;
    logic [3:0]                    fifo_count;

    logic [PHASE_WIDTH_DEF-1:0]    w_phase;
    logic [FREQ_WIDTH_DEF-1:0]     w_freq;
    logic [AMP_WIDTH_DEF-1:0]      w_amp;
    logic [ENV_WORD_WIDTH_DEF-1:0] w_env_word;
    logic [CFG_WIDTH_DEF-1:0]      w_cfg;
    logic                          w_cstrobe, w_late_err, w_busy;
    logic [7:0]                    w_cur_time;
    logic [3:0]                    w_fifo_count;

    pulse_scheduler_if cmd_if ();
    pulse_scheduler_if #(.TIME_WIDTH(8)) wcmd_if ();

    pulse_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .time_rst   (time_rst),
        .cmd        (cmd_if.slave),
        .phase      (phase),
        .freq       (freq),
        .amp        (amp),
        .env_word   (env_word),
        .cfg        (cfg),
        .cstrobe    (cstrobe),
        .cur_time   (cur_time),
        .fifo_count (fifo_count),
        .late_err   (late_err),
        .err_clr    (err_clr),
        .busy       (busy)
    );

    pulse_scheduler #(.TIME_WIDTH(8)) wdut (
        .clk        (clk),
        .reset      (reset),
        .time_rst   (w_time_rst),
        .cmd        (wcmd_if.slave),
        .phase      (w_phase),
        .freq       (w_freq),
        .amp        (w_amp),
        .env_word   (w_env_word),
        .cfg        (w_cfg),
        .cstrobe    (w_cstrobe),
        .cur_time   (w_cur_time),
        .fifo_count (w_fifo_count),
        .late_err   (w_late_err),
        .err_clr    (w_err_clr),
        .busy       (w_busy)
    );

    typedef struct {
        pulse_cmd_t  cmd;
        logic [31:0] strobe_time;
    } sb_t;

    sb_t        sb_q[$];
    sb_t        sb_e;
    pulse_cmd_t last_cmd;
    pulse_cmd_t w_cmd;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic pulse_cmd_t rand_cmd(input logic [31:0] t);
        pulse_cmd_t c;
        c.phase      = PHASE_WIDTH_DEF'($urandom);
        c.freq       = FREQ_WIDTH_DEF'($urandom);
        c.amp        = AMP_WIDTH_DEF'($urandom);
        c.cfg        = CFG_WIDTH_DEF'($urandom);
        c.env_word   = ENV_WORD_WIDTH_DEF'($urandom);
        c.time_stamp = t;
        return c;
    endfunction

    // Called just after a negedge; returns just after a later negedge.
    task automatic push(input logic [31:0] t, input logic [31:0] exp_strobe, input bit expect_it);
        pulse_cmd_t c;
        int n;
        c = rand_cmd(t);
        cmd_if.cmd_valid    = 1'b1;
        cmd_if.cmd_phase    = c.phase;
        cmd_if.cmd_freq     = c.freq;
        cmd_if.cmd_amp      = c.amp;
        cmd_if.cmd_cfg      = c.cfg;
        cmd_if.cmd_env_word = c.env_word;
        cmd_if.cmd_time     = c.time_stamp;
        n = 0;
        while (!cmd_if.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_if.cmd_ready) begin
            check("push_timeout", 0, 1);
        end else begin
            @(posedge clk);
            if (expect_it) sb_q.push_back('{cmd: c, strobe_time: exp_strobe});
        end
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_time(input logic [31:0] t);
        int n;
        n = 0;
        while (cur_time !== t && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (cur_time !== t) check("wait_time_timeout", cur_time, t);
    endtask

    task automatic w_wait_time(input logic [7:0] t);
        int n;
        n = 0;
        while (w_cur_time !== t && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (w_cur_time !== t) check("w_wait_time_timeout", w_cur_time, t);
    endtask

    task automatic w_push(input logic [7:0] t);
        w_cmd                = rand_cmd({24'h0, t});
        wcmd_if.cmd_valid    = 1'b1;
        wcmd_if.cmd_phase    = w_cmd.phase;
        wcmd_if.cmd_freq     = w_cmd.freq;
        wcmd_if.cmd_amp      = w_cmd.amp;
        wcmd_if.cmd_cfg      = w_cmd.cfg;
        wcmd_if.cmd_env_word = w_cmd.env_word;
        wcmd_if.cmd_time     = t;
        @(posedge clk);
        @(negedge clk);
        wcmd_if.cmd_valid = 1'b0;
    endtask

    // Returns the number of negedges until w_cstrobe is seen (bounded).
    task automatic w_wait_strobe(output int n);
        n = 0;
        while (!w_cstrobe && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!w_cstrobe) check("w_strobe_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (!reset && cstrobe) begin
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                sb_e     = sb_q.pop_front();
                last_cmd = sb_e.cmd;
                check("strobe_time", cur_time, sb_e.strobe_time);
                check("strobe_fields", {phase, freq, amp, env_word, cfg},
                      {sb_e.cmd.phase, sb_e.cmd.freq, sb_e.cmd.amp, sb_e.cmd.env_word,
                       sb_e.cmd.cfg});
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; time_rst = 1'b0; err_clr = 1'b0;
        w_time_rst = 1'b0; w_err_clr = 1'b0;
        cmd_if.cmd_valid = 1'b0; wcmd_if.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cur_time", cur_time, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_cstrobe", cstrobe, 0);
        check("rst_fields", {phase, freq, amp, env_word, cfg}, 0);
        check("rst_late_err", late_err, 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", cmd_if.cmd_ready, 1);
        check("timer_after_reset", cur_time, 1);

        // Single command far in the future.
        wait_time(10);
        push(100, 101, 1);
        check("count_one", fifo_count, 1);
        check("busy_one", busy, 1);
        wait_time(101);
        check("count_zero", fifo_count, 0);
        check("busy_zero", busy, 0);
        @(negedge clk);
        check("strobe_single_cycle", cstrobe, 0);
        check("fields_held", {phase, amp}, {last_cmd.phase, last_cmd.amp});

        // Fill the buffer, then offer a ninth command while full.
        time_rst = 1'b1;
        @(negedge clk);
        time_rst = 1'b0;
        check("time_rst_zero", cur_time, 0);
        for (int i = 0; i < 8; i++) push(50 + i, 51 + i, 1);
        check("count_full", fifo_count, 8);
        check("ready_full", cmd_if.cmd_ready, 0);
        push(60, 61, 1);
        check("ninth_accept_time", cur_time, 52);
        check("count_push_pop", fifo_count, 7);
        wait_time(62);
        check("no_late_burst", late_err, 0);
        check("drained_burst", fifo_count, 0);

        // Two equal timestamps: second one is late.
        time_rst = 1'b1;
        @(negedge clk);
        time_rst = 1'b0;
        push(200, 201, 1);
`ifdef PULSE_SCHED_LATE_DROP_EN
        push(200, 0, 0);
`else
        push(200, 202, 1);
`endif
        wait_time(205);
        check("late_set", late_err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("late_cleared", late_err, 0);

        // err_clr coincides with a late pop: set wins, then a lone clear works.
        push(300, 301, 1);
`ifdef PULSE_SCHED_LATE_DROP_EN
        push(300, 0, 0);
`else
        push(300, 302, 1);
`endif
        wait_time(301);
        err_clr = 1'b1;
        @(negedge clk);
        check("late_set_wins", late_err, 1);
        @(negedge clk);
        err_clr = 1'b0;
        check("late_clear_alone", late_err, 0);

        // Reset with pending commands that would otherwise fire soon.
        time_rst = 1'b1;
        @(negedge clk);
        time_rst = 1'b0;
        push(10, 0, 0);
        push(11, 0, 0);
        push(12, 0, 0);
        check("count_three", fifo_count, 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_count", fifo_count, 0);
        check("rst_mid_fields", {phase, freq, amp, env_word, cfg}, 0);
        check("rst_mid_busy", busy, 0);
        @(negedge clk);
        check("rst_mid_no_strobe", cstrobe, 0);
        wait_time(20);

        // 8-bit timer: time_rst near the top of the range, head at 5.
        w_wait_time(8'hE0);
        w_push(8'h05);
        w_wait_time(8'hF0);
        w_time_rst = 1'b1;
        @(negedge clk);
        w_time_rst = 1'b0;
        w_wait_strobe(n);
        check("w_rst_strobe_delay", n, 6);
        check("w_rst_strobe_time", w_cur_time, 8'h06);
        check("w_rst_fields", {w_phase, w_freq, w_amp, w_env_word, w_cfg},
              {w_cmd.phase, w_cmd.freq, w_cmd.amp, w_cmd.env_word, w_cmd.cfg});

        // 8-bit timer: natural wrap with head at 1.
        w_wait_time(8'hF8);
        w_push(8'h01);
        w_wait_strobe(n);
        check("w_wrap_strobe_time", w_cur_time, 8'h02);
        check("w_wrap_fields", {w_phase, w_amp}, {w_cmd.phase, w_cmd.amp});
        check("w_wrap_no_late", w_late_err, 0);

        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
